// File: rtl/lock_pkg.sv
// lock_pkg: shared FSM state type, digit geometry and one-hot check for the keypad entry sequencer
package lock_pkg;

    localparam int DIGIT_W    = 10;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_FAIL,
        ST_LOCKOUT
    } state_t;

    function automatic logic is_onehot(input logic [DIGIT_W-1:0] v);
        return (v != '0) && ((v & (v - DIGIT_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise the raw keypad and emit one pulse per debounced one-hot press
// Ports: clk/rst_n clock and async active-low reset; hold_i forces the "wait for release" state;
//        key_i raw keypad; key_valid_o one-cycle accept pulse; key_onehot_o accepted digit.
module key_debounce
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    input  logic [DIGIT_W-1:0] key_i,
    output logic               key_valid_o,
    output logic [DIGIT_W-1:0] key_onehot_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DIGIT_W-1:0] sync1_q, sync2_q, prev_q;
    logic [CW-1:0]      cnt_q, cnt_d, run;
    logic               armed_q, armed_d, target, hit;

    // armed_q: waiting for a stable press; otherwise waiting for a stable release.
    // Holding clears armed so a key held across the hold needs a fresh press.
    always_comb begin
        target  = armed_q ? is_onehot(sync2_q) : (sync2_q == '0);
        run     = !target ? '0 : (sync2_q == prev_q && cnt_q != '0) ? cnt_q + 1'b1 : CW'(1);
        hit     = run == CW'(DEBOUNCE_CYCLES);
        cnt_d   = (hold_i || hit) ? '0 : run;
        armed_d = !hold_i && (armed_q ^ hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign key_valid_o  = hit && armed_q && !hold_i;
    assign key_onehot_o = sync2_q;

endmodule

// File: rtl/keypad_entry_sequencer.sv
// keypad_entry_sequencer: collect four debounced digits, sample the comparator, drive unlock/lockout
// Ports: clk/rst_n clock and async active-low reset; key raw keypad; clear abandons entry;
//        lock_ok comparator result; a1..a4 one-hot slots; digit_cnt digits held;
//        unlock door level; error wrong-code pulse; locked_out lockout level.
module keypad_entry_sequencer
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int UNLOCK_CYCLES   = 500,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] key,
    input  logic               clear,
    input  logic               lock_ok,
    output logic [DIGIT_W-1:0] a1,
    output logic [DIGIT_W-1:0] a2,
    output logic [DIGIT_W-1:0] a3,
    output logic [DIGIT_W-1:0] a4,
    output logic [2:0]         digit_cnt,
    output logic               unlock,
    output logic               error,
    output logic               locked_out
);

    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    state_t                             state_q, state_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] slots_q, slots_d;
    logic [2:0]                         cnt_q, cnt_d;
    logic [FW-1:0]                      fails_q, fails_d, fails_inc;
    logic [TW-1:0]                      timer_q, timer_d;
    logic                               key_valid;
    logic [DIGIT_W-1:0]                 key_onehot;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (state_q == ST_LOCKOUT),
        .key_i        (key),
        .key_valid_o  (key_valid),
        .key_onehot_o (key_onehot)
    );

    // The shared timer is loaded with length-1 on entry to UNLOCKED/LOCKOUT and the state
    // exits on the edge where it reads zero, giving exactly the programmed number of cycles.
    always_comb begin
        state_d   = state_q;
        slots_d   = slots_q;
        cnt_d     = cnt_q;
        fails_d   = fails_q;
        timer_d   = timer_q - 1'b1;
        fails_inc = (fails_q == FW'(MAX_FAILS)) ? fails_q : fails_q + 1'b1;
        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    slots_d = '0;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    slots_d[cnt_q[IW-1:0]] = key_onehot;
                    cnt_d                  = cnt_q + 1'b1;
                    state_d                = (cnt_q == 3'(NUM_DIGITS - 1)) ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_CHECK: begin
                state_d = lock_ok ? ST_UNLOCKED : ST_FAIL;
                fails_d = lock_ok ? '0 : fails_q;
                timer_d = TW'(UNLOCK_CYCLES - 1);
            end
            ST_UNLOCKED: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    slots_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                fails_d = fails_inc;
                slots_d = '0;
                cnt_d   = '0;
                state_d = (fails_inc == FW'(MAX_FAILS)) ? ST_LOCKOUT : ST_ENTRY;
                timer_d = TW'(LOCKOUT_CYCLES - 1);
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    fails_d = '0;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ENTRY;
            slots_q <= '0;
            cnt_q   <= '0;
            fails_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            slots_q <= slots_d;
            cnt_q   <= cnt_d;
            fails_q <= fails_d;
            timer_q <= timer_d;
        end
    end

    assign a1         = slots_q[0];
    assign a2         = slots_q[1];
    assign a3         = slots_q[2];
    assign a4         = slots_q[3];
    assign digit_cnt  = cnt_q;
    assign unlock     = state_q == ST_UNLOCKED;
    assign error      = state_q == ST_FAIL;
    assign locked_out = state_q == ST_LOCKOUT;

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// tb_keypad_entry_sequencer: vector table, directed corner sequences and randomized presses vs a press-level model
module tb_keypad_entry_sequencer;

    localparam int DEB  = 4;
    localparam int UNL  = 8;
    localparam int MAXF = 3;
    localparam int LOCK = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic [9:0] key   = '0;
    logic [9:0] a1, a2, a3, a4;
    logic [2:0] digit_cnt;
    logic       unlock, error, locked_out, lock_ok;

    int n_cmp = 0;
    int n_bad = 0;

    // comparator for code 0-9-3-1
    assign lock_ok = a1 == 10'h001 && a2 == 10'h200 && a3 == 10'h008 && a4 == 10'h002;

    always #5 clk = ~clk;

    keypad_entry_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .UNLOCK_CYCLES  (UNL),
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .clear      (clear),
        .lock_ok    (lock_ok),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .a4         (a4),
        .digit_cnt  (digit_cnt),
        .unlock     (unlock),
        .error      (error),
        .locked_out (locked_out)
    );

    int         u_run = 0, u_last = 0, u_rises = 0;
    int         l_run = 0, l_last = 0;
    int         e_run = 0, e_pulses = 0, e_long = 0;
    logic [9:0] cap [4];

    always @(negedge clk) begin
        if (unlock) begin
            if (u_run == 0) begin
                u_rises++;
                cap[0] = a1;
                cap[1] = a2;
                cap[2] = a3;
                cap[3] = a4;
            end
            u_run++;
        end else if (u_run != 0) begin
            u_last = u_run;
            u_run  = 0;
        end
        if (locked_out) l_run++;
        else if (l_run != 0) begin
            l_last = l_run;
            l_run  = 0;
        end
        if (error) begin
            if (e_run == 0) e_pulses++;
            e_run++;
            if (e_run > 1) e_long++;
        end else e_run = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [9:0] k, input int h, input int r);
        key = k;
        cyc(h);
        key = '0;
        cyc(r);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(4);
    endtask

    task automatic do_reset();
        key   = '0;
        clear = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic enter_code(input logic [9:0] d0, input logic [9:0] d1,
                              input logic [9:0] d2, input logic [9:0] d3);
        press(d0, 6, 6);
        press(d1, 6, 6);
        press(d2, 6, 6);
        press(d3, 6, 6);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " a1"}, a1, 0);
        chk({tag, " a4"}, a4, 0);
        chk({tag, " digit_cnt"}, digit_cnt, 0);
        chk({tag, " unlock"}, unlock, 0);
        chk({tag, " error"}, error, 0);
        chk({tag, " locked_out"}, locked_out, 0);
    endtask

    typedef struct {
        logic [9:0] k;
        int         h;
        int         r;
        int         cnt;
    } vec_t;

    vec_t       tbl [7];
    logic [9:0] m_slot [3];
    int         m_cnt, h, r, r0, e0, el0;
    bit         m_armed, valid;
    logic [9:0] k;

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        chk("reset a2", a2, 0);
        chk("reset a3", a3, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // press table: accept needs hold >= 4, re-arm needs release >= 4 after an accept
        tbl[0] = '{10'h004, 6, 6, 1};
        tbl[1] = '{10'h010, 3, 6, 1};
        tbl[2] = '{10'h030, 6, 6, 1};
        tbl[3] = '{10'h100, 5, 2, 2};
        tbl[4] = '{10'h100, 6, 6, 2};
        tbl[5] = '{10'h000, 6, 6, 2};
        tbl[6] = '{10'h080, 4, 3, 3};
        for (int i = 0; i < 7; i++) begin
            press(tbl[i].k, tbl[i].h, tbl[i].r);
            chk($sformatf("table[%0d] digit_cnt", i), digit_cnt, tbl[i].cnt);
        end
        chk("table a1", a1, 10'h004);
        chk("table a2", a2, 10'h100);
        chk("table a3", a3, 10'h080);
        clear_pulse();
        chk("table clear digit_cnt", digit_cnt, 0);

        // correct code
        r0 = u_rises;
        e0 = e_pulses;
        press(10'h001, 6, 6);
        press(10'h200, 6, 6);
        press(10'h008, 6, 6);
        chk("code digit_cnt=3", digit_cnt, 3);
        chk("code a1", a1, 10'h001);
        chk("code a2", a2, 10'h200);
        chk("code a3", a3, 10'h008);
        press(10'h002, 6, 6);
        cyc(12);
        chk("code unlock rises", u_rises - r0, 1);
        chk("code unlock length", u_last, UNL);
        chk("code cap a1", cap[0], 10'h001);
        chk("code cap a2", cap[1], 10'h200);
        chk("code cap a3", cap[2], 10'h008);
        chk("code cap a4", cap[3], 10'h002);
        chk("code no error", e_pulses - e0, 0);
        chk("code digit_cnt back to 0", digit_cnt, 0);
        chk("code a1 zeroed", a1, 0);

        // bounce and invalid
        repeat (4) begin
            key = 10'h200;
            cyc(2);
            key = '0;
            cyc(2);
        end
        press(10'h208, 10, 6);
        chk("bounce digit_cnt", digit_cnt, 0);

        // hold and repeat
        press(10'h008, 40, 2);
        press(10'h008, 6, 6);
        chk("hold digit_cnt", digit_cnt, 1);
        chk("hold a1", a1, 10'h008);
        chk("hold a2", a2, 0);
        clear_pulse();
        chk("hold clear", digit_cnt, 0);

        // clear after 2 digits, then clear on the 3rd accept edge
        press(10'h001, 6, 6);
        press(10'h200, 6, 6);
        chk("clear pre digit_cnt", digit_cnt, 2);
        clear_pulse();
        chk("clear digit_cnt", digit_cnt, 0);
        chk("clear a1", a1, 0);
        chk("clear a2", a2, 0);
        press(10'h001, 6, 6);
        press(10'h200, 6, 6);
        key = 10'h008;
        cyc(5);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        key   = '0;
        cyc(6);
        chk("clear+accept digit_cnt", digit_cnt, 0);
        chk("clear+accept a1", a1, 0);
        chk("clear+accept a3", a3, 0);

        // three wrong codes -> lockout
        e0  = e_pulses;
        el0 = e_long;
        r0  = u_rises;
        repeat (3) enter_code(10'h002, 10'h002, 10'h002, 10'h002);
        chk("wrong error pulses", e_pulses - e0, 3);
        chk("wrong error width", e_long - el0, 0);
        chk("wrong locked_out", locked_out, 1);
        chk("wrong no unlock", u_rises - r0, 0);
        press(10'h001, 6, 2);
        chk("lockout ignores key", digit_cnt, 0);
        key = 10'h200;
        cyc(10);
        chk("lockout ended", locked_out, 0);
        chk("lockout length", l_last, LOCK);
        chk("held key after lockout", digit_cnt, 0);
        key = '0;
        cyc(6);
        enter_code(10'h001, 10'h200, 10'h008, 10'h002);
        cyc(12);
        chk("post-lockout unlock", u_rises - r0, 1);
        chk("post-lockout unlock length", u_last, UNL);

        // async reset mid-UNLOCKED
        press(10'h001, 6, 6);
        press(10'h200, 6, 6);
        press(10'h008, 6, 6);
        key = 10'h002;
        cyc(6);
        key = '0;
        cyc(3);
        chk("mid-unlock unlock", unlock, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst in unlock");
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        press(10'h004, 6, 6);
        chk("resume after unlock rst", digit_cnt, 1);
        chk("resume after unlock rst a1", a1, 10'h004);
        clear_pulse();

        // async reset mid-LOCKOUT
        repeat (3) enter_code(10'h002, 10'h002, 10'h002, 10'h002);
        chk("mid-lockout locked_out", locked_out, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst in lockout");
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        press(10'h004, 6, 6);
        chk("resume after lockout rst", digit_cnt, 1);

        // randomized presses vs press-level model
        for (int t = 0; t < 30; t++) begin
            do_reset();
            m_armed = 1'b1;
            m_cnt   = 0;
            for (int s = 0; s < 3; s++) m_slot[s] = '0;
            for (int p = 0; p < 8 && m_cnt < 3; p++) begin
                valid = $urandom_range(0, 4) != 0;
                if (valid) k = 10'b1 << $urandom_range(0, 9);
                else begin
                    int b0;
                    b0 = $urandom_range(0, 9);
                    k  = (10'b1 << b0) | (10'b1 << ((b0 + 1 + $urandom_range(0, 8)) % 10));
                end
                h = $urandom_range(1, 7);
                r = $urandom_range(1, 7);
                press(k, h, r);
                if (valid && m_armed && h >= DEB) begin
                    m_slot[m_cnt] = k;
                    m_cnt++;
                    m_armed = 1'b0;
                end
                if (r >= DEB) m_armed = 1'b1;
            end
            cyc(8);
            chk($sformatf("rand[%0d] digit_cnt", t), digit_cnt, m_cnt);
            chk($sformatf("rand[%0d] a1", t), a1, m_slot[0]);
            chk($sformatf("rand[%0d] a2", t), a2, m_slot[1]);
            chk($sformatf("rand[%0d] a3", t), a3, m_slot[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_entry_sequencer.md
# keypad_entry_sequencer

Collects four debounced one-hot keypad digits in sequence and presents them as the four 10-bit one-hot digit words consumed by the combinational code-lock comparator. It samples the comparator's match result and drives the unlock output. It also counts failed attempts and enforces a lockout period. It sits directly upstream of the lock comparator and is the only sequential stage between the raw keypad and the door actuator.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to accept a key or a release.
- UNLOCK_CYCLES, 500: cycles `unlock` stays high after a correct code.
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout.
- LOCKOUT_CYCLES, 1000: cycles during which keys are ignored after MAX_FAILS.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- key  in  10: raw keypad, bit n = digit n pressed. Asynchronous to clk.
- clear  in  1: abandon the current entry.
- lock_ok  in  1: match result from the comparator for the current a1..a4.
- a1, a2, a3, a4  out  10 each: one-hot digit slots (a1 = first digit entered).
- digit_cnt  out  3: digits captured in the current entry, 0..4.
- unlock  out  1: door release, level.
- error  out  1: one-cycle pulse on a wrong code.
- locked_out  out  1: high during lockout.

## Operation
- `key` passes through a 2-flop synchroniser.
- A synchronised value is a valid key only if exactly one bit is set.
- Debounce accepts a key when the same valid value has been sampled DEBOUNCE_CYCLES consecutive times.
- After an accept, `key` must read all-zero for DEBOUNCE_CYCLES consecutive samples before another accept. Holding a key never repeats.
- Multi-bit or changing values restart the debounce count.
- FSM states: ENTRY, CHECK, UNLOCKED, FAIL, LOCKOUT. Reset state is ENTRY.
- ENTRY:
  - An accepted key is written to slot a[digit_cnt+1] and digit_cnt increments.
  - When the 4th digit is written, the FSM goes to CHECK.
  - `clear` zeroes all slots and digit_cnt. If `clear` and an accept occur on the same edge, `clear` wins and the key is dropped.
- CHECK: lasts exactly one cycle; lock_ok is sampled at its closing edge.
  - lock_ok=1: go to UNLOCKED and zero the fail count.
  - lock_ok=0: go to FAIL.
- UNLOCKED:
  - `unlock`=1 for UNLOCK_CYCLES cycles.
  - Keys and `clear` are ignored.
  - On exit, slots and digit_cnt are zeroed and the FSM returns to ENTRY.
- FAIL: lasts one cycle.
  - `error`=1 and the fail count increments.
  - If the new count equals MAX_FAILS, go to LOCKOUT; otherwise go to ENTRY with slots cleared.
- LOCKOUT:
  - `locked_out`=1 for LOCKOUT_CYCLES cycles.
  - Keys and `clear` are ignored, and the debounce logic is held in reset.
  - On exit, the fail count is zeroed and the FSM goes to ENTRY.
- Zeroed slots encode as digit 0 downstream, so lock_ok is only meaningful in CHECK and is ignored in every other state.
- The fail count width is $clog2(MAX_FAILS+1). It saturates and never wraps.

## Timing
- Reset values: a1..a4=0, digit_cnt=0, unlock=0, error=0, locked_out=0, fail count 0, debounce idle, state ENTRY.
- Assertion of rst_n low mid-sequence aborts immediately, including during UNLOCKED and LOCKOUT.
- Key-to-slot latency: 2 synchroniser cycles + DEBOUNCE_CYCLES. The slot is visible the cycle after the accepting edge.
- 4th accept to CHECK: the same edge. `unlock` or `error` rises one cycle later.
- `unlock` high for exactly UNLOCK_CYCLES cycles. The first new key can be accepted no earlier than the cycle after `unlock` falls.
- `error` is high for exactly 1 cycle per wrong code.
- `locked_out` rises in the cycle after the MAX_FAILS-th `error` and lasts exactly LOCKOUT_CYCLES cycles.
- A key held through the end of LOCKOUT is not accepted until it has been released and pressed again.

## Structure
- Package `lock_pkg` holds:
  - the FSM state enum;
  - DIGIT_W=10 and NUM_DIGITS=4;
  - the one-hot-valid check function.
- Sub-module `key_debounce` contains the synchroniser, the one-hot check, the stable/release counters and a one-cycle `key_valid` + 10-bit `key_onehot` output.
- The top level holds the FSM, slots, fail counter and a shared down-counter for UNLOCK_CYCLES and LOCKOUT_CYCLES.

## Test plan
All scenarios use the lock comparator with code 0-9-3-1, parameters reduced to DEBOUNCE=4, UNLOCK=8, LOCKOUT=16.
- Correct code: keys 0,9,3,1, each held 6 cycles and released 6 cycles → a1=10'h001, a2=10'h200, a3=10'h008, a4=10'h002; `unlock` high for exactly 8 cycles; `error` never asserted; digit_cnt returns to 0.
- Bounce and invalid input: key 9 toggling every 2 cycles, then 10'h208 held 10 cycles → no capture and digit_cnt stays 0.
- Hold and repeat: key 3 held 40 cycles → exactly one capture. Key 3 pressed again without a ≥4-cycle release → no second capture.
- Three wrong codes (1,1,1,1 ×3) → three 1-cycle `error` pulses, then `locked_out` for exactly 16 cycles. The correct code entered during lockout is ignored; entered after lockout it unlocks.
- `clear` after 2 digits, and `clear` on the same edge as a 3rd accept → slots zeroed, digit_cnt=0, and the concurrent key is not stored.
- rst_n pulsed low for 1 cycle in mid-UNLOCKED and in mid-LOCKOUT → all outputs at reset values asynchronously; normal entry resumes after release.
